// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - instruction cache request/response bus
interface inst_fetcher_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_data;

  modport master (
    output ic_req,
    output ic_addr,
    input  ic_valid,
    input  ic_data
  );

  modport slave (
    input  ic_req,
    input  ic_addr,
    output ic_valid,
    output ic_data
  );
endinterface

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - PC owner and instruction fetch front end (optional next-line prefetch: FETCHER_PREFETCH_EN)
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           rob_clear,
  input  logic [31:0]    rob_new_pc,
  input  logic           f_ok,
  input  logic [31:0]    f_next_pc,
  output logic           inst_valid,
  output logic [31:0]    inst_addr,
  output logic [31:0]    inst_data,
  inst_fetcher_if.master ic
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        req_q;
  logic [31:0] addr_q;

`ifdef FETCHER_PREFETCH_EN
  logic        pf_valid;
  logic        pf_pend;
  logic [31:0] pf_addr;
  logic [31:0] pf_data;
`endif

  assign ic.ic_req  = req_q;
  assign ic.ic_addr = addr_q;

  // Fetch sequencing: reset > frozen > redirect > normal FETCH/WAIT/HOLD flow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      inst_valid <= 1'b0;
      inst_addr  <= 32'd0;
      inst_data  <= 32'd0;
`ifdef FETCHER_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_pend    <= 1'b0;
      pf_addr    <= 32'd0;
      pf_data    <= 32'd0;
`endif
    end else if (!rdy_in) begin
      // Whole block frozen; the cache is frozen with us.
    end else if (rob_clear) begin
      pc         <= rob_new_pc;
      inst_valid <= 1'b0;
`ifdef FETCHER_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_pend    <= 1'b0;
`endif
      if (req_q && !ic.ic_valid) begin
        // Request cannot be cancelled: keep it open and throw its answer away.
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        req_q <= 1'b0;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: begin
          req_q  <= 1'b1;
          addr_q <= pc;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ic.ic_valid) begin
            req_q <= 1'b0;
            if (drop) begin
              drop  <= 1'b0;
              state <= S_FETCH;
            end else begin
              inst_data  <= ic.ic_data;
              inst_addr  <= addr_q;
              inst_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
`ifdef FETCHER_PREFETCH_EN
          if (f_ok) begin
            pc       <= f_next_pc;
            pf_valid <= 1'b0;
            pf_pend  <= 1'b0;
            if (pf_valid && f_next_pc == pf_addr) begin
              // Buffered next line: present it straight away.
              inst_addr <= pf_addr;
              inst_data <= pf_data;
            end else if (pf_pend && f_next_pc == pf_addr && ic.ic_valid) begin
              inst_addr <= pf_addr;
              inst_data <= ic.ic_data;
              req_q     <= 1'b0;
            end else if (pf_pend && f_next_pc == pf_addr) begin
              // Wanted line is in flight; WAIT adopts its response.
              inst_valid <= 1'b0;
              state      <= S_WAIT;
            end else if (pf_pend && !ic.ic_valid) begin
              // Wrong line in flight: discard it, FETCH then issues the new pc.
              inst_valid <= 1'b0;
              drop       <= 1'b1;
              state      <= S_WAIT;
            end else begin
              inst_valid <= 1'b0;
              req_q      <= 1'b1;
              addr_q     <= f_next_pc;
              state      <= S_WAIT;
            end
          end else if (pf_pend) begin
            if (ic.ic_valid) begin
              pf_valid <= 1'b1;
              pf_pend  <= 1'b0;
              pf_data  <= ic.ic_data;
              req_q    <= 1'b0;
            end
          end else if (!pf_valid && !req_q) begin
            req_q   <= 1'b1;
            addr_q  <= inst_addr + 32'd4;
            pf_addr <= inst_addr + 32'd4;
            pf_pend <= 1'b1;
          end
`else
          if (f_ok) begin
            pc         <= f_next_pc;
            inst_valid <= 1'b0;
            req_q      <= 1'b1;
            addr_q     <= f_next_pc;
            state      <= S_WAIT;
          end
`endif
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed plus randomized self-checking bench for inst_fetcher
module tb_inst_fetcher;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic [31:0] rob_new_pc;
  logic        f_ok;
  logic [31:0] f_next_pc;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;

  inst_fetcher_if ic_bus ();

  inst_fetcher #(.RESET_PC(RESET_PC)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rob_clear  (rob_clear),
    .rob_new_pc (rob_new_pc),
    .f_ok       (f_ok),
    .f_next_pc  (f_next_pc),
    .inst_valid (inst_valid),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .ic         (ic_bus)
  );

  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: where the next presented instruction must come from,
  // and a redirect epoch that tells live cache answers from stale ones.
  logic [31:0] exp_pc;
  int          epoch;
  int          req_epoch;
  int          presented;
  int          lat_cfg;
  int          lat_cur;
  int          cnt;
  bit          served;

  logic        p_iv, p_req;
  logic [31:0] p_ia, p_id, p_addr;
  logic        a_rst, a_rdy, a_clear, a_fok, a_icv;
  logic [31:0] a_newpc, a_nextpc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h0101_0101 + 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    rdy_in    = 1'b1;
    rob_clear = 1'b0;
    f_ok      = 1'b0;
  endtask

  task automatic update();
    bit accepted;
    bit kept;
    if (a_rst) begin
      exp_pc = RESET_PC;
      epoch++;
    end else begin
      if (!a_rdy) begin
        check("frz_iv",   32'(inst_valid),    32'(p_iv));
        check("frz_ia",   inst_addr,          p_ia);
        check("frz_id",   inst_data,          p_id);
        check("frz_req",  32'(ic_bus.ic_req), 32'(p_req));
        check("frz_addr", ic_bus.ic_addr,     p_addr);
      end else begin
        accepted = p_iv && a_fok && !a_clear;
        kept     = a_icv && (req_epoch == epoch) && !a_clear;
        if (a_clear) begin
          exp_pc = a_newpc;
          epoch++;
          check("clr_iv", 32'(inst_valid), 32'd0);
        end else if (accepted) begin
          exp_pc = a_nextpc;
          check("acc_iv",  32'(inst_valid),    32'd0);
          check("acc_req", 32'(ic_bus.ic_req), 32'd1);
        end else if (kept) begin
          presented++;
          check("lat_iv", 32'(inst_valid), 32'd1);
        end else if (p_iv) begin
          check("hold_iv", 32'(inst_valid), 32'd1);
          check("hold_ia", inst_addr, p_ia);
          check("hold_id", inst_data, p_id);
        end else begin
          check("idle_iv", 32'(inst_valid), 32'd0);
        end
      end
      if (inst_valid) begin
        check("pres_addr", inst_addr, exp_pc);
        check("pres_data", inst_data, mem(inst_addr));
      end
      if (ic_bus.ic_req) begin
        if (p_req) begin
          check("req_stable", ic_bus.ic_addr, p_addr);
        end else begin
          check("req_addr", ic_bus.ic_addr, exp_pc);
          req_epoch = epoch;
          lat_cur   = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
        end
      end
    end
  endtask

  // One clock: cache answers, snapshot, edge, then compare against the model.
  task automatic step();
    ic_bus.ic_valid = 1'b0;
    ic_bus.ic_data  = $urandom;
    if (!ic_bus.ic_req || rst_in) begin
      served = 1'b0;
      cnt    = 0;
    end else if (!served && rdy_in) begin
      if (cnt + 1 >= lat_cur) begin
        ic_bus.ic_valid = 1'b1;
        ic_bus.ic_data  = mem(ic_bus.ic_addr);
        served          = 1'b1;
      end else begin
        cnt++;
      end
    end
    p_iv = inst_valid;  p_ia = inst_addr;  p_id = inst_data;
    p_req = ic_bus.ic_req;  p_addr = ic_bus.ic_addr;
    a_rst = rst_in;  a_rdy = rdy_in;  a_clear = rob_clear;  a_newpc = rob_new_pc;
    a_fok = f_ok;  a_nextpc = f_next_pc;  a_icv = ic_bus.ic_valid;
    @(posedge clk_in);
    @(negedge clk_in);
    update();
  endtask

  task automatic wait_present(input string tag);
    for (int i = 0; i < 40 && !inst_valid; i++) step();
    check(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic accept(input logic [31:0] npc);
    f_ok      = 1'b1;
    f_next_pc = npc;
    step();
    f_ok      = 1'b0;
  endtask

  initial begin
    int base;
    exp_pc = RESET_PC;  epoch = 0;  req_epoch = -1;  presented = 0;
    lat_cfg = 2;  lat_cur = 2;  cnt = 0;  served = 1'b0;
    rob_new_pc = 32'd0;  f_next_pc = 32'd0;
    ic_bus.ic_valid = 1'b0;  ic_bus.ic_data = 32'd0;
    idle();
    rst_in = 1'b1;
    @(negedge clk_in);
    step();
    step();
    check("rst_iv",   32'(inst_valid),    32'd0);
    check("rst_ia",   inst_addr,          32'd0);
    check("rst_id",   inst_data,          32'd0);
    check("rst_req",  32'(ic_bus.ic_req), 32'd0);
    check("rst_addr", ic_bus.ic_addr,     32'd0);

    rst_in = 1'b0;
    step();
    check("first_req",  32'(ic_bus.ic_req), 32'd1);
    check("first_addr", ic_bus.ic_addr,     32'd0);
    wait_present("first_present");
    check("first_ia", inst_addr, 32'h0);
    check("first_id", inst_data, 32'h13);

    accept(32'h4);
    check("seq_iv",   32'(inst_valid),    32'd0);
    check("seq_req",  32'(ic_bus.ic_req), 32'd1);
    check("seq_addr", ic_bus.ic_addr,     32'h4);
    wait_present("seq_present");
    for (int i = 0; i < 10; i++) step();
    check("hold10_iv", 32'(inst_valid), 32'd1);
    check("hold10_ia", inst_addr,       32'h4);
    check("hold10_id", inst_data,       mem(32'h4));

    accept(32'h100);
    check("jal_addr", ic_bus.ic_addr, 32'h100);
    wait_present("jal_present");
    check("jal_ia", inst_addr, 32'h100);

    lat_cfg = 4;
    accept(32'h8);
    check("wait8_addr", ic_bus.ic_addr, 32'h8);
    step();
    rob_clear  = 1'b1;
    rob_new_pc = 32'h200;
    step();
    rob_clear  = 1'b0;
    check("clr_keep_req",  32'(ic_bus.ic_req), 32'd1);
    check("clr_keep_addr", ic_bus.ic_addr,     32'h8);
    wait_present("clr_present");
    check("clr_ia", inst_addr, 32'h200);
    check("clr_id", inst_data, mem(32'h200));

    lat_cfg   = 2;
    rdy_in    = 1'b0;
    f_ok      = 1'b1;
    f_next_pc = 32'h300;
    for (int i = 0; i < 5; i++) step();
    check("frz5_iv", 32'(inst_valid), 32'd1);
    check("frz5_ia", inst_addr,       32'h200);
    rdy_in = 1'b1;
    step();
    f_ok = 1'b0;
    check("thaw_iv",   32'(inst_valid), 32'd0);
    check("thaw_addr", ic_bus.ic_addr,  32'h300);
    wait_present("thaw_present");

    accept(32'hFFFF_FFFC);
    wait_present("top_present");
    check("top_ia", inst_addr, 32'hFFFF_FFFC);
    accept(inst_addr + 32'd4);
    wait_present("wrap_present");
    check("wrap_ia", inst_addr, 32'h0);

    lat_cfg = 0;
    base    = presented;
    for (int i = 0; i < 1500; i++) begin
      rdy_in     = ($urandom % 8) != 0;
      rob_clear  = ($urandom % 20) == 0;
      rob_new_pc = ($urandom % 1024) * 4;
      f_ok       = ($urandom % 10) < 4;
      f_next_pc  = ($urandom % 2 == 0) ? inst_addr + 32'd4 : ($urandom % 1024) * 4;
      step();
    end
    idle();
    for (int i = 0; i < 20; i++) step();
    check("rand_progress", 32'(presented - base >= 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
